// File: rtl/pokey_sample_decimator.sv
// rtl/pokey_sample_decimator.sv - box-car decimator turning POKEY channel levels into 16-bit PCM
// Optional one-pole DC blocker is compiled in when POKEY_DCBLOCK_EN is defined.
module pokey_sample_decimator #(
  parameter int LOG2_DIV = 11
`ifdef POKEY_DCBLOCK_EN
  ,
  parameter int DC_SHIFT = 8
`endif
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  raw_wave,
  input  logic [31:0] audc,
  output logic [15:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun
);
  localparam int ACCW = LOG2_DIV + 6;

  logic [LOG2_DIV-1:0] cnt_q, cnt_d;
  logic [ACCW-1:0]     acc_q, acc_d, acc_fin;
  logic [15:0]         sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic [5:0]          level;
  logic                last_cycle, load;
  logic [15:0]         x, y;
  logic                unused_bits;

  always_comb begin
    level = '0;
    for (int i = 0; i < 4; i++) begin
      if (raw_wave[i] | audc[8*i+4]) level = level + {2'b00, audc[8*i +: 4]};
    end
  end

  assign acc_fin    = acc_q + {{(ACCW-6){1'b0}}, level};
  assign last_cycle = &cnt_q;
  // Top 16 bits of the window sum are offset-binary; flipping the MSB makes them signed.
  assign x          = acc_fin[ACCW-1 -: 16] ^ 16'h8000;
  // A completed window is only accepted if the output slot is free or being emptied now.
  assign load       = last_cycle & (~valid_q | sample_ready);

  always_comb begin
    cnt_d     = cnt_q + LOG2_DIV'(1);
    acc_d     = last_cycle ? '0 : acc_fin;
    valid_d   = load | (valid_q & ~sample_ready);
    overrun_d = overrun_q | (last_cycle & valid_q & ~sample_ready);
    sample_d  = load ? y : sample_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      sample_q  <= 16'h0000;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef POKEY_DCBLOCK_EN
  localparam int DCW = 16 + DC_SHIFT;

  logic signed [DCW-1:0] dc_acc_q, dc_acc_d, dc_full;
  logic signed [16:0]    diff;

  // The DC estimate only advances on samples that actually reach the output.
  always_comb begin
    dc_full = dc_acc_q >>> DC_SHIFT;
    diff    = $signed({x[15], x}) - $signed({dc_full[15], dc_full[15:0]});
    if (diff[16] != diff[15]) y = diff[16] ? 16'h8000 : 16'h7FFF;
    else                      y = diff[15:0];
    dc_acc_d = load ? dc_acc_q + DCW'(diff) : dc_acc_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) dc_acc_q <= '0;
    else     dc_acc_q <= dc_acc_d;
  end

  assign unused_bits = ^{acc_fin, dc_full, audc[31:29], audc[23:21], audc[15:13], audc[7:5]};
`else
  assign y           = x;
  assign unused_bits = ^{acc_fin, audc[31:29], audc[23:21], audc[15:13], audc[7:5]};
`endif

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
endmodule
